// File: rtl/pmod_pkg.sv
// Shared constants for the PMOD walking-one loopback checker.
package pmod_pkg;

    // Number of looped-back SYZYGY0 PMOD pins.
    localparam int unsigned WIDTH_DEF  = 32;
    // Default input filter length in clocks.
    localparam int unsigned STABLE_DEF = 16;
    // Step period of the walking-one generator, in clocks.
    localparam int unsigned STEP_CYC   = 2**24;
    // Default step timeout: two generator step periods.
    localparam int unsigned TIMEOUT_DEF = 2 * STEP_CYC;

    // Checker states.
    localparam logic [1:0] ST_SEARCH = 2'd0;
    localparam logic [1:0] ST_LOCKED = 2'd1;
    localparam logic [1:0] ST_FAULT  = 2'd2;

endpackage

// File: rtl/pin_sync_filter.sv
// Two-flop synchroniser plus stability filter for a bus of asynchronous pins.
// A new value is accepted only after STABLE_CYC identical synchronised samples.
module pin_sync_filter
    import pmod_pkg::*;
#(
    parameter int unsigned WIDTH      = WIDTH_DEF,
    parameter int unsigned STABLE_CYC = STABLE_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] pin_in,
    output logic [WIDTH-1:0] accepted,
    output logic             new_val,
    output logic             settled
);

    localparam int unsigned CW = $clog2(STABLE_CYC + 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [CW-1:0]    stab_cnt;
    logic [CW-1:0]    stab_d;
    logic [WIDTH-1:0] accepted_d;
    logic             new_val_d;

    // Stability counter and acceptance; sync1 is the incoming sample compared
    // against the last synchronised sample held in sync2.
    always_comb begin
        stab_d     = stab_cnt;
        accepted_d = accepted;
        new_val_d  = 1'b0;
        if (sync1 != sync2) begin
            stab_d = '0;
        end else if (stab_cnt != CW'(STABLE_CYC)) begin
            stab_d = stab_cnt + CW'(1);
        end
        if ((stab_d == CW'(STABLE_CYC)) && (stab_cnt != CW'(STABLE_CYC)) &&
            (sync2 != accepted)) begin
            accepted_d = sync2;
            new_val_d  = 1'b1;
        end
    end

    // Synchroniser, filter and accepted-value registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1    <= '0;
            sync2    <= '0;
            stab_cnt <= '0;
            accepted <= '0;
            new_val  <= 1'b0;
            settled  <= 1'b0;
        end else begin
            sync1    <= pin_in;
            sync2    <= sync1;
            stab_cnt <= stab_d;
            accepted <= accepted_d;
            new_val  <= new_val_d;
            settled  <= (stab_d == CW'(STABLE_CYC));
        end
    end

endmodule

// File: rtl/pmod_walk_checker.sv
// Receive-side checker for the looped-back walking-one PMOD pattern:
// locks onto a single rotating '1', verifies each rotate-left step,
// counts laps and latches a mask of failing pins on fault.
module pmod_walk_checker
    import pmod_pkg::*;
#(
    parameter int unsigned WIDTH      = WIDTH_DEF,
    parameter int unsigned STABLE_CYC = STABLE_DEF,
    parameter int unsigned TIMEOUT    = TIMEOUT_DEF
) (
    input  logic             clk30,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] pin_in,
    input  logic             clear,
    output logic             locked,
    output logic             fault,
    output logic             step_strobe,
    output logic [7:0]       lap_cnt,
    output logic [15:0]      err_cnt,
    output logic [WIDTH-1:0] fail_mask
);

    localparam int unsigned SCW = $clog2(WIDTH);
    localparam int unsigned TW  = $clog2(TIMEOUT + 1);

    logic [WIDTH-1:0] accepted;
    logic             new_val;
    logic             settled;

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [WIDTH-1:0] expected;
    logic [WIDTH-1:0] expected_d;
    logic [SCW-1:0]   step_cnt;
    logic [SCW-1:0]   step_d;
    logic [TW-1:0]    tmo_cnt;
    logic [TW-1:0]    tmo_d;
    logic [7:0]       lap_d;
    logic [15:0]      err_d;
    logic [WIDTH-1:0] mask_d;
    logic             strobe_d;

    // Rotate left by one, bit WIDTH-1 wraps to bit 0.
    function automatic logic [WIDTH-1:0] rotl1(input logic [WIDTH-1:0] v);
        return {v[WIDTH-2:0], v[WIDTH-1]};
    endfunction

    pin_sync_filter #(
        .WIDTH      (WIDTH),
        .STABLE_CYC (STABLE_CYC)
    ) u_filter (
        .clk      (clk30),
        .rst_n    (rst_n),
        .pin_in   (pin_in),
        .accepted (accepted),
        .new_val  (new_val),
        .settled  (settled)
    );

    // Next-state, counters and fault capture.
    always_comb begin
        state_d    = state_q;
        expected_d = expected;
        step_d     = step_cnt;
        tmo_d      = tmo_cnt;
        lap_d      = lap_cnt;
        err_d      = err_cnt;
        mask_d     = fail_mask;
        strobe_d   = 1'b0;
        case (state_q)
            ST_SEARCH: begin
                if (settled && $onehot(accepted)) begin
                    state_d    = ST_LOCKED;
                    expected_d = rotl1(accepted);
                    step_d     = '0;
                    tmo_d      = '0;
                end
            end
            ST_LOCKED: begin
                tmo_d = new_val ? '0 : tmo_cnt + TW'(1);
                if (new_val && (accepted == expected)) begin
                    strobe_d   = 1'b1;
                    expected_d = rotl1(accepted);
                    if (step_cnt == SCW'(WIDTH - 1)) begin
                        step_d = '0;
                        if (lap_cnt != 8'hFF) begin
                            lap_d = lap_cnt + 8'd1;
                        end
                    end else begin
                        step_d = step_cnt + SCW'(1);
                    end
                end else if (new_val || (tmo_cnt == TW'(TIMEOUT - 1))) begin
                    // Mismatch and timeout together still make one fault entry.
                    state_d = ST_FAULT;
                    mask_d  = accepted ^ expected;
                    if (err_cnt != 16'hFFFF) begin
                        err_d = err_cnt + 16'd1;
                    end
                end
            end
            ST_FAULT: begin
                if (clear) begin
                    state_d = ST_SEARCH;
                    mask_d  = '0;
                end
            end
            default: begin
                state_d = ST_SEARCH;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk30 or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_SEARCH;
            expected    <= '0;
            step_cnt    <= '0;
            tmo_cnt     <= '0;
            lap_cnt     <= '0;
            err_cnt     <= '0;
            fail_mask   <= '0;
            step_strobe <= 1'b0;
            locked      <= 1'b0;
            fault       <= 1'b0;
        end else begin
            state_q     <= state_d;
            expected    <= expected_d;
            step_cnt    <= step_d;
            tmo_cnt     <= tmo_d;
            lap_cnt     <= lap_d;
            err_cnt     <= err_d;
            fail_mask   <= mask_d;
            step_strobe <= strobe_d;
            locked      <= (state_d == ST_LOCKED);
            fault       <= (state_d == ST_FAULT);
        end
    end

endmodule
